// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter sharing a single left barrel shifter for SLL/SRL/SRA/ROL

module left_barrel_shifter (
    input  logic [31:0] a,
    input  logic [4:0]  s,
    output logic [31:0] y
);
    logic [31:0] stage [6];

    always_comb begin
        stage[0] = a;
        for (int i = 0; i < 5; i++) begin
            stage[i+1] = s[i] ? (stage[i] << (1 << i)) : stage[i];
        end
        y = stage[5];
    end
endmodule

module shift_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id
);
    typedef enum logic {IDLE, ROT2} state_t;

    state_t      state, state_next;
    logic        prio;
    logic [31:0] temp;
    logic [31:0] lat_data;
    logic [4:0]  lat_shamt;
    logic        lat_id;

    logic        can_accept, win, accept, rol_two;
    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_op;
    logic [31:0] sh_a, sh_y, pass_result;
    logic [4:0]  sh_s;
    logic        rev, invert;

    function automatic logic [31:0] bitrev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // prio names the requester that wins the next tie
    always_comb begin
        can_accept = reset && (state == IDLE) && (!resp_valid || resp_ready);
        if (req0_valid && req1_valid) win = (ROUND_ROBIN != 0) ? prio : 1'b0;
        else                          win = !req0_valid;
        req0_ready = can_accept && req0_valid && !win;
        req1_ready = can_accept && req1_valid && win;
        accept     = req0_ready || req1_ready;
        sel_data   = win ? req1_data  : req0_data;
        sel_shamt  = win ? req1_shamt : req0_shamt;
        sel_op     = win ? req1_op    : req0_op;
        rol_two    = (sel_op == 2'b11) && (sel_shamt != 5'd0);
    end

    // right shifts run through the left shifter on bit-reversed operands
    always_comb begin
        rev    = 1'b0;
        invert = 1'b0;
        sh_a   = sel_data;
        sh_s   = sel_shamt;
        if (state == ROT2) begin
            rev  = 1'b1;
            sh_a = bitrev(lat_data);
            sh_s = 5'd0 - lat_shamt;
        end else begin
            case (sel_op)
                2'b01: rev = 1'b1;
                2'b10: begin
                    rev    = 1'b1;
                    invert = sel_data[31];
                end
                default: rev = 1'b0;
            endcase
            if (rev) sh_a = bitrev(invert ? ~sel_data : sel_data);
        end
        pass_result = rev ? bitrev(sh_y) : sh_y;
        if (invert) pass_result = ~pass_result;
    end

    left_barrel_shifter u_shifter (
        .a (sh_a),
        .s (sh_s),
        .y (sh_y)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && rol_two) state_next = ROT2;
            ROT2:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_id    <= 1'b0;
            temp       <= 32'd0;
            prio       <= 1'b0;
            lat_data   <= 32'd0;
            lat_shamt  <= 5'd0;
            lat_id     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_data  <= sel_data;
                lat_shamt <= sel_shamt;
                lat_id    <= win;
                if (ROUND_ROBIN != 0) prio <= !win;
            end
            // acceptance implies the result register is free, so ROT2 never stalls
            if (state == ROT2) begin
                resp_valid <= 1'b1;
                resp_data  <= temp | pass_result;
                resp_id    <= lat_id;
            end else if (accept && rol_two) begin
                temp       <= pass_result;
                resp_valid <= 1'b0;
            end else if (accept) begin
                resp_valid <= 1'b1;
                resp_data  <= pass_result;
                resp_id    <= win;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter, round-robin and fixed-priority instances

module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, resp_ready = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [4:0]  s0 = '0, s1 = '0;
    logic [1:0]  o0 = '0, o1 = '0;
    logic [1:0]  r0, r1, rv, rid;
    logic [31:0] rd [2];

    int checks = 0;
    int errors = 0;

    // reference state per instance: index 0 round-robin, index 1 fixed priority
    bit          m_rv [2];
    bit          m_rid [2];
    bit          m_rot [2];
    bit          m_rotid [2];
    bit          m_prio [2];
    logic [31:0] m_rd [2];
    logic [31:0] m_rotd [2];

    always #5 clk = ~clk;

    shift_arbiter #(.ROUND_ROBIN(1)) dut_rr (
        .clock(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0[0]), .req0_data(d0), .req0_shamt(s0), .req0_op(o0),
        .req1_valid(v1), .req1_ready(r1[0]), .req1_data(d1), .req1_shamt(s1), .req1_op(o1),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_data(rd[0]), .resp_id(rid[0])
    );

    shift_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clock(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0[1]), .req0_data(d0), .req0_shamt(s0), .req0_op(o0),
        .req1_valid(v1), .req1_ready(r1[1]), .req1_data(d1), .req1_shamt(s1), .req1_op(o1),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_data(rd[1]), .resp_id(rid[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
        int n;
        n = s;
        case (op)
            2'd0:    return a << n;
            2'd1:    return a >> n;
            2'd2:    return $unsigned($signed(a) >>> n);
            default: return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
        endcase
    endfunction

    function automatic logic [1:0] exp_ready(input int i);
        bit can, w;
        can = reset && !m_rot[i] && (!m_rv[i] || resp_ready);
        if (v0 && v1) w = (i == 0) ? m_prio[i] : 1'b0;
        else          w = !v0;
        return {can && v1 && w, can && v0 && !w};
    endfunction

    function automatic logic [4:0] pick_s();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic step();
        logic [1:0]  er;
        bit          w;
        logic [1:0]  op;
        logic [4:0]  sa;
        logic [31:0] res;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            er = exp_ready(i);
            check($sformatf("i%0d_rdy0", i), r0[i], er[0]);
            check($sformatf("i%0d_rdy1", i), r1[i], er[1]);
            check($sformatf("i%0d_rv", i), rv[i], m_rv[i]);
            if (m_rv[i]) begin
                check($sformatf("i%0d_data", i), rd[i], m_rd[i]);
                check($sformatf("i%0d_id", i), rid[i], m_rid[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            er = exp_ready(i);
            if (!reset) begin
                m_rv[i] = 0; m_rd[i] = '0; m_rid[i] = 0;
                m_rot[i] = 0; m_prio[i] = 0;
            end else if (m_rot[i]) begin
                m_rv[i] = 1; m_rd[i] = m_rotd[i]; m_rid[i] = m_rotid[i]; m_rot[i] = 0;
            end else if (er != 2'b00) begin
                w   = er[1];
                op  = w ? o1 : o0;
                sa  = w ? s1 : s0;
                res = ref_op(op, w ? d1 : d0, sa);
                if (op == 2'd3 && sa != 5'd0) begin
                    m_rot[i] = 1; m_rotd[i] = res; m_rotid[i] = w; m_rv[i] = 0;
                end else begin
                    m_rv[i] = 1; m_rd[i] = res; m_rid[i] = w;
                end
                if (i == 0) m_prio[i] = !w;
            end else if (resp_ready) begin
                m_rv[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; resp_ready = 1;
        step();
        step();
    endtask

    task automatic do_reset();
        reset = 0;
        step();
        reset = 1;
    endtask

    task automatic single(input bit who, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] s, input logic [31:0] exp, input int lat);
        idle();
        if (who) begin v1 = 1; o1 = op; d1 = a; s1 = s; end
        else     begin v0 = 1; o0 = op; d0 = a; s0 = s; end
        #1;
        check("acc_rdy", who ? r1[0] : r0[0], 1);
        step();
        v0 = 0; v1 = 0;
        if (lat == 2) begin
            v0 = 1; v1 = 1;
            #1;
            check("mid_rdy", {r1[0], r0[0]}, 0);
            check("mid_rv", rv[0], 0);
            v0 = 0; v1 = 0;
            step();
        end
        check("res_rv", rv[0], 1);
        check("res_data", rd[0], exp);
        check("res_id", rid[0], who);
    endtask

    initial begin
        step();
        v0 = 1; v1 = 1;
        #1;
        check("rst_rdy0", r0[0], 0);
        check("rst_rdy1", r1[0], 0);
        check("rst_rv", rv[0], 0);
        check("rst_data", rd[0], 0);
        check("rst_id", rid[0], 0);
        v0 = 0; v1 = 0;
        reset = 1;

        single(0, 2'd0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1);
        single(0, 2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1);
        single(0, 2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1);
        single(1, 2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 2);
        single(1, 2'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);
        single(0, 2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1);
        single(1, 2'd2, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1);
        single(0, 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1);

        do_reset();
        resp_ready = 1; v0 = 1; v1 = 1; o0 = 2'd0; o1 = 2'd0;
        d0 = 32'h1; d1 = 32'h2; s0 = 5'd1; s1 = 5'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant0", r0[0], (k + 1) % 2);
            check("rr_grant1", r1[0], k % 2);
            check("fp_grant0", r0[1], 1);
            check("fp_grant1", r1[1], 0);
            step();
        end

        idle();
        v0 = 1; o0 = 2'd0; d0 = 32'd5; s0 = 5'd1;
        step();
        d0 = 32'd7; resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rv", rv[0], 1);
            check("bp_data", rd[0], 32'd10);
            check("bp_id", rid[0], 0);
            check("bp_rdy", {r1[0], r0[0]}, 0);
            step();
        end
        resp_ready = 1;
        #1;
        check("drain_acc", r0[0], 1);
        step();
        v0 = 0;
        check("b2b_rv", rv[0], 1);
        check("b2b_data", rd[0], 32'd14);

        idle();
        v1 = 1; o1 = 2'd3; d1 = 32'hA5A5_0F0F; s1 = 5'd3;
        step();
        v1 = 0;
        reset = 0;
        step();
        reset = 1;
        check("rot_rst_rv", rv[0], 0);
        v0 = 1; o0 = 2'd0;
        #1;
        check("rot_rst_idle", r0[0], 1);
        v0 = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rot_rst_norsp", rv[0], 0);
        end

        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 99) != 0);
            v0         = ($urandom_range(0, 2) != 0);
            v1         = ($urandom_range(0, 2) != 0);
            d0         = $urandom;
            d1         = $urandom;
            o0         = 2'($urandom_range(0, 3));
            o1         = 2'($urandom_range(0, 3));
            s0         = pick_s();
            s1         = pick_s();
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
